// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the single 6502 CPU memory port between fetch, execute and OAM DMA.
// Latency: ack is combinational; the memory access is registered on the next edge; read data
//   and rvalid follow one edge after that (ack -> mem_en +1 -> rvalid/rdata +2).
// Backpressure: a request that is not acked is not stored; the requester holds its request
//   until it sees ack. halt freezes arbitration, while in-flight reads still complete.
//
// Ports:
//   phi1, reset_n (sync, active-low), halt
//   fetch_req/addr -> fetch_ack, fetch_rvalid
//   exec_req/we/addr/wdata -> exec_ack, exec_rvalid
//   dma_req/we/addr/wdata -> dma_ack, dma_rvalid
//   mem_en/we/addr/wdata (registered) and mem_rdata (same cycle as mem_en)
//   rdata (registered, shared), dma_busy (registered; state is not CPU)
module mem_bus_arbiter #(
  parameter int ADDR_WIDTH   = 16,
  parameter int REG_WIDTH    = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  phi1,
  input  logic                  reset_n,
  input  logic                  halt,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_ack,
  output logic                  fetch_rvalid,
  input  logic                  exec_req,
  input  logic                  exec_we,
  input  logic [ADDR_WIDTH-1:0] exec_addr,
  input  logic [REG_WIDTH-1:0]  exec_wdata,
  output logic                  exec_ack,
  output logic                  exec_rvalid,
  input  logic                  dma_req,
  input  logic                  dma_we,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  input  logic [REG_WIDTH-1:0]  dma_wdata,
  output logic                  dma_ack,
  output logic                  dma_rvalid,
  output logic [REG_WIDTH-1:0]  rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [REG_WIDTH-1:0]  mem_wdata,
  input  logic [REG_WIDTH-1:0]  mem_rdata,
  output logic                  dma_busy
);

  localparam logic [1:0] ST_CPU   = 2'd0;
  localparam logic [1:0] ST_ALIGN = 2'd1;
  localparam logic [1:0] ST_DMA   = 2'd2;

  localparam logic [1:0] OWN_NONE  = 2'd0;
  localparam logic [1:0] OWN_FETCH = 2'd1;
  localparam logic [1:0] OWN_EXEC  = 2'd2;
  localparam logic [1:0] OWN_DMA   = 2'd3;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [1:0]            r_state;
  logic [1:0]            w_next_state;
  logic [3:0]            r_starve_cnt;
  logic                  w_starved;

  logic                  w_fetch_ack;
  logic                  w_exec_ack;
  logic                  w_dma_ack;
  logic                  w_any_ack;

  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic                  w_sel_we;
  logic [REG_WIDTH-1:0]  w_sel_wdata;
  logic [1:0]            w_sel_owner;

  logic                  r_mem_en;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [REG_WIDTH-1:0]  r_mem_wdata;
  // Owner of the access currently on the bus, so its read data is returned to the right port.
  logic [1:0]            r_owner;
  logic [REG_WIDTH-1:0]  r_rdata;
  logic                  r_fetch_rvalid;
  logic                  r_exec_rvalid;
  logic                  r_dma_rvalid;
  logic                  r_dma_busy;

  assign w_starved = (r_starve_cnt == LIMIT);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge phi1) begin
    if (!reset_n) begin
      r_state <= ST_CPU;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_next_state = r_state;
    if (!halt) begin
      case (r_state)
        ST_CPU:   if (dma_req) w_next_state = ST_ALIGN;
        // ALIGN always lasts exactly one unhalted cycle, even if dma_req has already dropped.
        ST_ALIGN: w_next_state = ST_DMA;
        ST_DMA:   if (!dma_req) w_next_state = ST_CPU;
        default:  w_next_state = ST_CPU;
      endcase
    end
  end

  // ---------------- FSM: outputs (grants) ----------------
  always_comb begin
    w_fetch_ack = 1'b0;
    w_exec_ack  = 1'b0;
    w_dma_ack   = 1'b0;
    if (reset_n && !halt) begin
      case (r_state)
        ST_CPU: begin
          // A DMA request in CPU state steals the bus: nobody is granted in the request cycle.
          if (!dma_req) begin
            if (fetch_req && (w_starved || !exec_req)) begin
              w_fetch_ack = 1'b1;
            end else if (exec_req) begin
              w_exec_ack = 1'b1;
            end
          end
        end
        ST_DMA:  w_dma_ack = dma_req;
        default: ;
      endcase
    end
  end

  assign w_any_ack = w_fetch_ack | w_exec_ack | w_dma_ack;

  // Select the granted requester's access.
  always_comb begin
    w_sel_addr  = fetch_addr;
    w_sel_we    = 1'b0;
    w_sel_wdata = '0;
    w_sel_owner = OWN_NONE;
    if (w_fetch_ack) begin
      w_sel_addr  = fetch_addr;
      w_sel_owner = OWN_FETCH;
    end else if (w_exec_ack) begin
      w_sel_addr  = exec_addr;
      w_sel_we    = exec_we;
      w_sel_wdata = exec_wdata;
      w_sel_owner = OWN_EXEC;
    end else if (w_dma_ack) begin
      w_sel_addr  = dma_addr;
      w_sel_we    = dma_we;
      w_sel_wdata = dma_wdata;
      w_sel_owner = OWN_DMA;
    end
  end

  // ---------------- Memory access and read return pipeline ----------------
  always_ff @(posedge phi1) begin
    if (!reset_n) begin
      r_mem_en       <= 1'b0;
      r_mem_we       <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
      r_owner        <= OWN_NONE;
      r_rdata        <= '0;
      r_fetch_rvalid <= 1'b0;
      r_exec_rvalid  <= 1'b0;
      r_dma_rvalid   <= 1'b0;
      r_dma_busy     <= 1'b0;
    end else begin
      r_mem_en <= w_any_ack;
      if (w_any_ack) begin
        r_mem_we    <= w_sel_we;
        r_mem_addr  <= w_sel_addr;
        r_mem_wdata <= w_sel_wdata;
        r_owner     <= w_sel_owner;
      end else begin
        r_mem_we <= 1'b0;
      end

      // Read return is independent of halt so an access already on the bus always completes.
      r_fetch_rvalid <= r_mem_en && !r_mem_we && (r_owner == OWN_FETCH);
      r_exec_rvalid  <= r_mem_en && !r_mem_we && (r_owner == OWN_EXEC);
      r_dma_rvalid   <= r_mem_en && !r_mem_we && (r_owner == OWN_DMA);
      if (r_mem_en && !r_mem_we) begin
        r_rdata <= mem_rdata;
      end

      r_dma_busy <= (w_next_state != ST_CPU);
    end
  end

  // ---------------- Fetch anti-starvation counter ----------------
  always_ff @(posedge phi1) begin
    if (!reset_n) begin
      r_starve_cnt <= 4'd0;
    end else if (!halt) begin
      if (!fetch_req || w_fetch_ack) begin
        r_starve_cnt <= 4'd0;
      end else if (r_starve_cnt < LIMIT) begin
        r_starve_cnt <= r_starve_cnt + 4'd1;
      end
    end
  end

  assign fetch_ack    = w_fetch_ack;
  assign exec_ack     = w_exec_ack;
  assign dma_ack      = w_dma_ack;
  assign fetch_rvalid = r_fetch_rvalid;
  assign exec_rvalid  = r_exec_rvalid;
  assign dma_rvalid   = r_dma_rvalid;
  assign rdata        = r_rdata;
  assign mem_en       = r_mem_en;
  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign dma_busy     = r_dma_busy;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

  localparam int LIMIT = 4;

  logic        phi1;
  logic        reset_n;
  logic        halt;
  logic        fetch_req;
  logic [15:0] fetch_addr;
  logic        fetch_ack, fetch_rvalid;
  logic        exec_req, exec_we;
  logic [15:0] exec_addr;
  logic [7:0]  exec_wdata;
  logic        exec_ack, exec_rvalid;
  logic        dma_req, dma_we;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata;
  logic        dma_ack, dma_rvalid;
  logic [7:0]  rdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        dma_busy;

  logic [7:0]  mem [256];
  assign mem_rdata = mem[mem_addr[7:0]];

  mem_bus_arbiter #(.ADDR_WIDTH(16), .REG_WIDTH(8), .STARVE_LIMIT(LIMIT)) dut (
    .phi1(phi1), .reset_n(reset_n), .halt(halt),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack), .fetch_rvalid(fetch_rvalid),
    .exec_req(exec_req), .exec_we(exec_we), .exec_addr(exec_addr), .exec_wdata(exec_wdata),
    .exec_ack(exec_ack), .exec_rvalid(exec_rvalid),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rvalid(dma_rvalid),
    .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dma_busy(dma_busy)
  );

  initial begin
    phi1 = 1'b0;
    forever #5 phi1 = ~phi1;
  end

  typedef struct {
    int          due;
    logic [15:0] addr;
    logic        we;
    logic [7:0]  wdata;
  } mem_e_t;

  typedef struct {
    int          due;
    logic [2:0]  who;   // {fetch, exec, dma}
    logic [7:0]  data;
  } rd_e_t;

  mem_e_t mq[$];
  rd_e_t  rq[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_gnt = 0;   // 0 none, 1 fetch, 2 exec, 3 dma (model's grant in the cycle just ended)

  // Reference model: arbitration phase (0 CPU, 1 ALIGN, 2 DMA) and refused-fetch count.
  int m_phase  = 0;
  int m_starve = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- Monitor / scoreboard ----------------
  logic       exp_en;
  logic [2:0] exp_rv, exp_ack;
  int         g, nphase;
  mem_e_t     me;
  rd_e_t      re;

  always @(negedge phi1) begin
    cyc++;

    exp_en = (mq.size() > 0) && (mq[0].due == cyc);
    chk("mem_en", mem_en, exp_en);
    if (exp_en) begin
      me = mq.pop_front();
      if (mem_en) begin
        chk("mem_addr", mem_addr, me.addr);
        chk("mem_we", mem_we, me.we);
        if (me.we) chk("mem_wdata", mem_wdata, me.wdata);
      end
    end else begin
      chk("mem_we_idle", mem_we, 1'b0);
    end

    exp_rv = 3'b000;
    if ((rq.size() > 0) && (rq[0].due == cyc)) begin
      re = rq.pop_front();
      exp_rv = re.who;
      chk("rdata", rdata, re.data);
    end
    chk("rvalid", {fetch_rvalid, exec_rvalid, dma_rvalid}, exp_rv);

    chk("dma_busy", dma_busy, m_phase != 0);

    g = 0;
    nphase = m_phase;
    if (!reset_n) begin
      nphase = 0;
      m_starve = 0;
      while ((mq.size() > 0) && (mq[mq.size()-1].due > cyc)) void'(mq.pop_back());
      while ((rq.size() > 0) && (rq[rq.size()-1].due > cyc)) void'(rq.pop_back());
    end else if (!halt) begin
      if (m_phase == 0) begin
        if (dma_req) nphase = 1;
        else if (fetch_req && (m_starve == LIMIT || !exec_req)) g = 1;
        else if (exec_req) g = 2;
      end else if (m_phase == 1) begin
        nphase = 2;
      end else begin
        if (dma_req) g = 3;
        else nphase = 0;
      end
      if (!fetch_req || g == 1) m_starve = 0;
      else if (m_starve < LIMIT) m_starve = m_starve + 1;
    end

    exp_ack = {g == 1, g == 2, g == 3};
    chk("acks", {fetch_ack, exec_ack, dma_ack}, exp_ack);

    if (g != 0) begin
      me.due = cyc + 1;
      if (g == 1) begin me.addr = fetch_addr; me.we = 1'b0;    me.wdata = 8'h00;      end
      else if (g == 2) begin me.addr = exec_addr; me.we = exec_we; me.wdata = exec_wdata; end
      else begin me.addr = dma_addr; me.we = dma_we; me.wdata = dma_wdata; end
      mq.push_back(me);
      if (!me.we) begin
        re.due  = cyc + 2;
        re.who  = exp_ack;
        re.data = mem[me.addr[7:0]];
        rq.push_back(re);
      end
    end
    m_phase  = nphase;
    last_gnt = g;
  end

  // ---------------- Stimulus ----------------
  task automatic step();
    @(posedge phi1);
    #1;
  endtask

  int ecnt, dcnt, dleft;
  bit done;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h00] = 8'hA9;
    reset_n = 1'b0; halt = 1'b0;
    fetch_req = 1'b0; fetch_addr = '0;
    exec_req = 1'b0; exec_we = 1'b0; exec_addr = '0; exec_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    step(); step();
    reset_n = 1'b1;
    @(negedge phi1);
    chk("reset_mem_addr", mem_addr, 16'h0000);
    chk("reset_rdata", rdata, 8'h00);
    step();

    // Single fetch of 0x8000 returning 0xA9.
    fetch_req = 1'b1; fetch_addr = 16'h8000;
    step();
    chk("fetch_first_grant", last_gnt, 1);
    fetch_req = 1'b0;
    step(); step();

    // Starvation: exec wins STARVE_LIMIT times, then fetch.
    fetch_req = 1'b1; fetch_addr = 16'h9000;
    exec_req = 1'b1; exec_we = 1'b0; exec_addr = 16'h0010;
    ecnt = 0; done = 0;
    for (int i = 0; i < 12 && !done; i++) begin
      step();
      if (last_gnt == 2) begin ecnt++; exec_addr = exec_addr + 16'd1; end
      else if (last_gnt == 1) done = 1;
    end
    chk("starve_exec_count", ecnt, LIMIT);
    fetch_addr = 16'h9001;
    step();
    chk("starve_cleared_exec_wins", last_gnt, 2);
    fetch_req = 1'b0; exec_req = 1'b0;
    step(); step();

    // Exec write then read of the same address.
    exec_req = 1'b1; exec_we = 1'b1; exec_addr = 16'h0200; exec_wdata = 8'h55;
    step();
    exec_we = 1'b0;
    step();
    exec_req = 1'b0;
    step(); step();

    // DMA steal with CPU requests pending: three DMA writes.
    fetch_req = 1'b1; fetch_addr = 16'hA000;
    exec_req = 1'b1; exec_addr = 16'h0040;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h2004; dma_wdata = 8'h11;
    dcnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (last_gnt == 3) begin
        dcnt++; dma_addr = dma_addr + 16'd1; dma_wdata = dma_wdata + 8'd1;
        if (dcnt == 3) dma_req = 1'b0;
      end
      if (last_gnt == 1) fetch_addr = fetch_addr + 16'd1;
      if (last_gnt == 2) exec_addr = exec_addr + 16'd1;
    end
    chk("dma_grant_count", dcnt, 3);
    fetch_req = 1'b0; exec_req = 1'b0;
    step(); step();

    // Halt during back-to-back fetches.
    fetch_req = 1'b1; fetch_addr = 16'hC000;
    for (int i = 0; i < 8; i++) begin
      halt = (i == 3 || i == 4);
      step();
      if (last_gnt == 1) fetch_addr = fetch_addr + 16'd1;
    end
    halt = 1'b0; fetch_req = 1'b0;
    step(); step();

    // Reset in DMA state with a DMA read in flight.
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0300;
    step(); step(); step();
    chk("dma_read_granted", last_gnt, 3);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1; dma_req = 1'b0;
    @(negedge phi1);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    chk("rst_mem_wdata", mem_wdata, 8'h00);
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_dma_busy", dma_busy, 1'b0);
    step(); step();

    // Randomized traffic.
    dleft = 0;
    for (int i = 0; i < 3000; i++) begin
      if (fetch_req && last_gnt == 1) fetch_req = 1'b0;
      if (!fetch_req && $urandom_range(0, 3) != 0) begin
        fetch_req = 1'b1; fetch_addr = 16'($urandom);
      end
      if (exec_req && last_gnt == 2) exec_req = 1'b0;
      if (!exec_req && $urandom_range(0, 2) != 0) begin
        exec_req = 1'b1; exec_we = 1'($urandom); exec_addr = 16'($urandom); exec_wdata = 8'($urandom);
      end
      if (dma_req) begin
        if (last_gnt == 3) begin
          dleft--; dma_we = 1'($urandom); dma_addr = 16'($urandom); dma_wdata = 8'($urandom);
        end
        if (dleft <= 0) dma_req = 1'b0;
      end else if ($urandom_range(0, 19) == 0) begin
        dma_req = 1'b1; dleft = $urandom_range(0, 4);
        dma_we = 1'($urandom); dma_addr = 16'($urandom); dma_wdata = 8'($urandom);
      end
      halt = ($urandom_range(0, 15) == 0);
      reset_n = ($urandom_range(0, 199) != 0);
      step();
    end

    fetch_req = 1'b0; exec_req = 1'b0; dma_req = 1'b0; halt = 1'b0; reset_n = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("queues_drained", mq.size() + rq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Single-port memory bus arbiter and sequencer for the 6502 core. It shares the one CPU memory port between the instruction fetcher, the execute unit (operand and stack reads/writes) and the OAM DMA engine. It also enforces DMA bus-steal alignment and anti-starvation for instruction fetch. It sits between the core's requesters and the memory map, so memory sees one registered access per phi1 cycle.

## Interface
- ADDR_WIDTH, 16, address width
- REG_WIDTH, 8, data width
- STARVE_LIMIT, 4, consecutive refused fetch cycles before fetch outranks execute (1..15)

- phi1  in  1  clock; all logic on posedge
- reset_n  in  1  reset, synchronous, active-low
- halt  in  1  freezes arbitration; no acks, state and counters hold
- fetch_req  in  1  fetcher read request
- fetch_addr  in  ADDR_WIDTH  fetch address
- fetch_ack  out  1  combinational; request accepted this cycle
- fetch_rvalid  out  1  rdata holds fetch read data
- exec_req / exec_we  in  1 / 1  execute request; write when exec_we=1
- exec_addr / exec_wdata  in  ADDR_WIDTH / REG_WIDTH  execute address and write data
- exec_ack / exec_rvalid  out  1 / 1  as for fetch
- dma_req / dma_we  in  1 / 1  DMA request; write when dma_we=1
- dma_addr / dma_wdata  in  ADDR_WIDTH / REG_WIDTH  DMA address and write data
- dma_ack / dma_rvalid  out  1 / 1  as for fetch
- rdata  out  REG_WIDTH  registered read data, shared by all requesters
- mem_en  out  1  registered; access valid this cycle
- mem_we  out  1  registered; 1 = write
- mem_addr  out  ADDR_WIDTH  registered address
- mem_wdata  out  REG_WIDTH  registered write data
- mem_rdata  in  REG_WIDTH  memory read data, valid in the same cycle as mem_en
- dma_busy  out  1  registered; state is not CPU

## Operation
- States: CPU (reset), ALIGN, DMA.
- CPU, dma_req=0: exec beats fetch, unless starve_cnt == STARVE_LIMIT, in which case fetch beats exec. At most one ack per cycle.
- CPU, dma_req=1: no acks this cycle; next state ALIGN.
- ALIGN: exactly one cycle; no acks; next state DMA.
- DMA: dma_ack = dma_req. When dma_req=0, no acks that cycle; next state CPU.
- A request that is not acked is not stored. The requester holds req, addr, we and wdata until it sees ack.
- Acked access: on the next edge, mem_en=1 and mem_addr/mem_we/mem_wdata load the granted requester's values. With no ack, mem_en=0, mem_we=0, and addr/wdata hold their previous values.
- Reads: at the edge following a cycle with mem_en=1 and mem_we=0, rdata is loaded from mem_rdata and the owning requester's rvalid pulses for one cycle. Writes produce no rvalid.
- starve_cnt (4-bit): +1 on each cycle with fetch_req=1, fetch_ack=0 and halt=0, saturating at STARVE_LIMIT. Cleared on fetch_ack or fetch_req=0. Held during halt.
- halt=1: all acks 0, mem_en=0 from the next edge, state and starve_cnt hold. In-flight rvalid/rdata still complete.
- Reset: state CPU; all acks, rvalids, mem_en, mem_we and dma_busy 0; mem_addr, mem_wdata, rdata and starve_cnt 0. Any pending read return is discarded.
- Requests with ack=0 during reset are not remembered.

## Timing
- Ack is combinational from req, state, starve_cnt and halt.
- Read latency: ack at edge k → mem_en during (k, k+1] → rvalid and rdata during (k+1, k+2].
- Throughput is one access per cycle, pipelined back to back. The rvalid owner is tracked per cycle, so interleaved owners return correctly.
- DMA entry costs 2 dead cycles (request cycle plus ALIGN). DMA exit costs 1 dead cycle.
- dma_busy rises the edge after dma_req is first seen in CPU. It falls on the edge entering CPU.
- A dma_req that drops during ALIGN still passes through DMA, with one idle cycle, before returning to CPU.

## Test plan
- Fetch only, fetch_addr=0x8000 for one cycle, mem_rdata=0xA9 → fetch_ack same cycle, mem_en/mem_addr=0x8000 next cycle, fetch_rvalid=1 and rdata=0xA9 the cycle after.
- exec_req and fetch_req held together, STARVE_LIMIT=4 → exec acked 4 cycles, 5th ack goes to fetch, starve_cnt returns to 0.
- exec write 0x0200←0x55 followed by an exec read of 0x0200 → mem_we=1 then 0 on consecutive cycles; exec_rvalid only for the read.
- dma_req asserted with CPU requests pending, 3 DMA writes then dma_req low → 2 cycles of no acks, dma_ack on 3 cycles, 1 dead cycle, then CPU grants resume; dma_busy high across ALIGN and DMA.
- halt pulsed for 2 cycles during back-to-back fetches → no acks and mem_en=0 for those cycles, the in-flight rvalid still delivered, and starve_cnt unchanged.
- reset_n low for 1 cycle in the DMA state with a read in flight → next cycle all outputs are at their reset values, no rvalid, state CPU.
